// File: rtl/tf_addr_gen_pkg.sv
// Shared definitions for the twiddle-factor address generator.
// Covers transform size defaults, the stage counter width and the sequencer states.
package tf_addr_gen_pkg;

    localparam int TF_LOGN  = 10;
    localparam int TF_ADDRW = TF_LOGN + 1;
    localparam int STAGE_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tf_state_e;

endpackage

// File: rtl/tf_addr_gen_calc.sv
// Combinational twiddle address for one beat: idx = 2^s + group, where the top bit
// selects the forward or inverse half of the table.
module tf_addr_gen_calc
    import tf_addr_gen_pkg::*;
#(
    parameter int LOGN  = TF_LOGN,
    parameter int ADDRW = TF_ADDRW
) (
    input  logic               op,
    input  logic [STAGE_W-1:0] s,
    input  logic [LOGN-3:0]    c,
    output logic [ADDRW-1:0]   g1_addr,
    output logic [ADDRW-1:0]   g2_addr,
    output logic               special
);

    logic [LOGN-1:0] c_ext;
    logic [LOGN-1:0] base;
    logic [LOGN-1:0] g1;
    logic [LOGN-1:0] g2;

    always_comb begin
        c_ext = {2'b00, c};
        base  = LOGN'(1) << s;
        g1    = '0;
        g2    = '0;
        // Unit 2 sits N/4 butterflies above unit 1, i.e. 2^(s-1) groups higher.
        if (s != '0) begin
            g1 = c_ext >> (STAGE_W'(LOGN - 1) - s);
            g2 = g1 + (LOGN'(1) << (s - STAGE_W'(1)));
        end
        g1_addr = {op, base + g1};
        g2_addr = {op, base + g2};
        special = (s != '0);
    end

endmodule

// File: rtl/tf_addr_gen.sv
// Twiddle-ROM address sequencer: walks every NTT/INTT stage, two butterflies per beat.
// state   | meaning
// IDLE    | waiting for start; start issues the first beat on the same edge
// RUN     | one beat per non-stalled edge; a stalled edge inserts one invalid cycle
// DONE    | one-cycle done pulse after the last beat, start dropped here
module tf_addr_gen
    import tf_addr_gen_pkg::*;
#(
    parameter int LOGN  = TF_LOGN,
    parameter int ADDRW = TF_ADDRW
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               op_i,
    input  logic               stall,
    output logic               op,
    output logic               special_add,
    output logic [ADDRW-1:0]   gamma1_add,
    output logic [ADDRW-1:0]   gamma2_add,
    output logic               addr_valid,
    output logic [STAGE_W-1:0] stage,
    output logic               last,
    output logic               busy,
    output logic               done
);

    localparam int                 CW     = LOGN - 2;
    localparam logic [CW-1:0]      C_MAX  = '1;
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOGN - 1);

    tf_state_e          state_q, state_d;
    logic [STAGE_W-1:0] ps_q, ps_d;
    logic [CW-1:0]      pc_q, pc_d;
    logic               op_q, op_d;
    logic               special_q, special_d;
    logic [ADDRW-1:0]   g1_q, g1_d;
    logic [ADDRW-1:0]   g2_q, g2_d;
    logic               valid_q, valid_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               issue_op;
    logic [STAGE_W-1:0] issue_s;
    logic [CW-1:0]      issue_c;
    logic [STAGE_W-1:0] s_final;
    logic               issue_last;
    logic [STAGE_W-1:0] nxt_s;
    logic [CW-1:0]      nxt_c;
    logic               do_issue;
    logic [ADDRW-1:0]   calc_g1;
    logic [ADDRW-1:0]   calc_g2;
    logic               calc_special;

    // ps/pc point at the next beat to issue; in IDLE the first beat comes from op_i.
    always_comb begin
        if (state_q == ST_IDLE) begin
            issue_op = op_i;
            issue_s  = op_i ? S_LAST : '0;
            issue_c  = '0;
        end else begin
            issue_op = op_q;
            issue_s  = ps_q;
            issue_c  = pc_q;
        end
        s_final    = issue_op ? '0 : S_LAST;
        issue_last = (issue_s == s_final) && (issue_c == C_MAX);
        if (issue_c == C_MAX) begin
            nxt_c = '0;
            nxt_s = issue_op ? (issue_s - STAGE_W'(1)) : (issue_s + STAGE_W'(1));
        end else begin
            nxt_c = issue_c + CW'(1);
            nxt_s = issue_s;
        end
    end

    tf_addr_gen_calc #(
        .LOGN  (LOGN),
        .ADDRW (ADDRW)
    ) u_calc (
        .op      (issue_op),
        .s       (issue_s),
        .c       (issue_c),
        .g1_addr (calc_g1),
        .g2_addr (calc_g2),
        .special (calc_special)
    );

    always_comb begin
        state_d   = state_q;
        ps_d      = ps_q;
        pc_d      = pc_q;
        op_d      = op_q;
        special_d = special_q;
        g1_d      = g1_q;
        g2_d      = g2_q;
        valid_d   = 1'b0;
        stage_d   = stage_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        do_issue  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                last_d = 1'b0;
                if (start) begin
                    state_d  = ST_RUN;
                    op_d     = op_i;
                    busy_d   = 1'b1;
                    do_issue = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_q) begin
                    state_d = ST_DONE;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!stall) begin
                    do_issue = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (do_issue) begin
            g1_d      = calc_g1;
            g2_d      = calc_g2;
            special_d = calc_special;
            stage_d   = issue_s;
            last_d    = issue_last;
            valid_d   = 1'b1;
            ps_d      = nxt_s;
            pc_d      = nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ps_q      <= '0;
            pc_q      <= '0;
            op_q      <= 1'b0;
            special_q <= 1'b0;
            g1_q      <= '0;
            g2_q      <= '0;
            valid_q   <= 1'b0;
            stage_q   <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            special_q <= special_d;
            g1_q      <= g1_d;
            g2_q      <= g2_d;
            valid_q   <= valid_d;
            stage_q   <= stage_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign op          = op_q;
    assign special_add = special_q;
    assign gamma1_add  = g1_q;
    assign gamma2_add  = g2_q;
    assign addr_valid  = valid_q;
    assign stage       = stage_q;
    assign last        = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_tf_addr_gen.sv
// Bench for tf_addr_gen: reference beat list built from the twiddle indexing rules,
// compared beat by beat under random stalls, start noise and a mid-run reset.
module tb_tf_addr_gen;

    localparam int LOGN  = 10;
    localparam int ADDRW = LOGN + 1;
    localparam int N     = 1 << LOGN;
    localparam int BEATS = LOGN * N / 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic             op_i;
    logic             stall;
    logic             op;
    logic             special_add;
    logic [ADDRW-1:0] gamma1_add;
    logic [ADDRW-1:0] gamma2_add;
    logic             addr_valid;
    logic [3:0]       stage;
    logic             last;
    logic             busy;
    logic             done;

    tf_addr_gen #(.LOGN(LOGN), .ADDRW(ADDRW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .op_i        (op_i),
        .stall       (stall),
        .op          (op),
        .special_add (special_add),
        .gamma1_add  (gamma1_add),
        .gamma2_add  (gamma2_add),
        .addr_valid  (addr_valid),
        .stage       (stage),
        .last        (last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int g1;
        int g2;
        int st;
        int sp;
        int lst;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    beats, bubbles, first_cyc, done_cyc;
    bit    done_seen, done_prev, mon_en, run_op;
    int    prev_g1, prev_g2;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Butterfly j in stage s belongs to group j >> (LOGN-1-s); twiddle index is 2^s + group.
    task automatic build_exp(input bit o);
        exp_q.delete();
        for (int k = 0; k < LOGN; k++) begin
            int s;
            s = o ? (LOGN - 1 - k) : k;
            for (int c = 0; c < N / 4; c++) begin
                beat_t b;
                int    sh;
                sh    = LOGN - 1 - s;
                b.g1  = (o ? N : 0) + (1 << s) + (c >> sh);
                b.g2  = (o ? N : 0) + (1 << s) + ((c + N / 4) >> sh);
                b.st  = s;
                b.sp  = (s != 0) ? 1 : 0;
                b.lst = (k == LOGN - 1 && c == N / 4 - 1) ? 1 : 0;
                exp_q.push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rstn && mon_en) begin
            if (addr_valid) begin
                chk("busy_in_beat", busy, 1);
                if (exp_q.size() == 0) begin
                    chk("extra_beat", beats, BEATS - 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("gamma1", gamma1_add, e.g1);
                    chk("gamma2", gamma2_add, e.g2);
                    chk("stage", stage, e.st);
                    chk("special", special_add, e.sp);
                    chk("last", last, e.lst);
                end
                if (beats == 0) first_cyc = cyc;
                beats++;
                prev_g1 = int'(gamma1_add);
                prev_g2 = int'(gamma2_add);
            end else if (busy && !done && beats > 0) begin
                bubbles++;
                chk("hold_g1", gamma1_add, prev_g1);
                chk("hold_g2", gamma2_add, prev_g2);
                chk("last_in_bubble", last, 0);
            end
            if (busy) chk("op_held", op, run_op);
            if (done) begin
                chk("done_beats", beats, BEATS);
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
            if (done_prev) chk("busy_after_done", busy, 0);
            done_prev = done;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, addr_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_special"}, special_add, 0);
        chk({tag, "_op"}, op, 0);
        chk({tag, "_g1"}, gamma1_add, 0);
        chk({tag, "_g2"}, gamma2_add, 0);
        chk({tag, "_stage"}, stage, 0);
    endtask

    // mode: 0 clean, 1 random stalls, 2 five-cycle stall burst, 3 start/op noise, 4 reset at beat 1000
    task automatic run(input bit o, input int mode);
        int sampled;
        int stall_left;
        bit burst_done;
        stall_left = 0;
        burst_done = 1'b0;
        build_exp(o);
        beats     = 0;
        bubbles   = 0;
        first_cyc = -1;
        done_cyc  = -1;
        done_seen = 1'b0;
        done_prev = 1'b0;
        run_op    = o;
        mon_en    = 1'b1;
        @(posedge clk); #1;
        start   = 1'b1;
        op_i    = o;
        sampled = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done_seen) break;
            case (mode)
                1: stall = ($urandom_range(7) == 0);
                2: begin
                    if (beats == 700 && !burst_done) begin
                        stall_left = 5;
                        burst_done = 1'b1;
                    end
                    stall = (stall_left > 0);
                    if (stall_left > 0) stall_left--;
                end
                3: begin
                    start = 1'b1;
                    op_i  = 1'($urandom_range(1));
                end
                4: begin
                    if (beats >= 1000) begin
                        rstn = 1'b0;
                        @(posedge clk);
                        @(negedge clk);
                        check_reset("midrun_rst");
                        @(posedge clk); #1;
                        rstn = 1'b1;
                        repeat (10) @(posedge clk);
                        #1;
                        chk("no_done_after_rst", done_seen, 0);
                        chk("rst_beats_partial", beats, 1000);
                        return;
                    end
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("first_beat_latency", first_cyc, sampled + 2);
        chk("beat_count", beats, BEATS);
        chk("done_latency", done_cyc - first_cyc, BEATS + bubbles);
        chk("exp_left", exp_q.size(), 0);
        if (mode == 0 || mode == 3) chk("bubbles", bubbles, 0);
        if (mode == 2) chk("burst_bubbles", bubbles, 5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", addr_valid, 0);
    endtask

    initial begin
        rstn   = 1'b0;
        start  = 1'b0;
        op_i   = 1'b0;
        stall  = 1'b0;
        mon_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1;
        rstn = 1'b1;
        run(1'b0, 0);
        run(1'b1, 1);
        run(1'b0, 2);
        run(1'b1, 3);
        run(1'b0, 4);
        run(1'b0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
